// File: rtl/rx_fifo_read_arbiter.sv
// -----------------------------------------------------------------------------
// rx_fifo_read_arbiter
//
// Shares the edge-triggered RX FIFO pop port between two requesters:
//   A = host register read, B = loopback/diagnostic path.
// A granted pop drives Pop_Data high for POP_PULSE_CYCLES cycles, then low for
// SETTLE_CYCLES cycles. FIFO_Data is captured on the last low cycle, and the
// winner gets a one-cycle Ack with the captured word. If the FIFO is empty, no
// pop is issued and the Ack carries Rsp_Empty=1 one cycle after the grant.
//
// Build option:
//   RX_FIFO_ARB_FIXED_PRIO_EN  defined   -> fixed priority, A always beats B
//                              undefined -> round-robin (A wins first tie)
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   Req_A, Req_B     level requests, held until the matching Ack
//   Ack_A, Ack_B     one-cycle completion pulses (mutually exclusive)
//   Rsp_Data         captured FIFO word, held until the next capture
//   Rsp_Empty        valid with Ack; 1 = FIFO was empty, nothing popped
//   FIFO_Data        FIFO Data_Out
//   FIFO_Empty       FIFO empty flag
//   Data_Rdy         FIFO write strobe (observed only)
//   BIST_Mode        blocks new grants while high
//   Pop_Data         registered pop strobe to the FIFO
//   Write_Collision  one-cycle pulse when a write strobe rises during a pop
// -----------------------------------------------------------------------------
module rx_fifo_read_arbiter #(
  parameter int DATA_BITS        = 8,
  parameter int POP_PULSE_CYCLES = 2,
  parameter int SETTLE_CYCLES    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Req_A,
  input  logic                 Req_B,
  output logic                 Ack_A,
  output logic                 Ack_B,
  output logic [DATA_BITS-1:0] Rsp_Data,
  output logic                 Rsp_Empty,
  input  logic [DATA_BITS-1:0] FIFO_Data,
  input  logic                 FIFO_Empty,
  input  logic                 Data_Rdy,
  input  logic                 BIST_Mode,
  output logic                 Pop_Data,
  output logic                 Write_Collision
);

  localparam int MAX_CNT = (POP_PULSE_CYCLES > SETTLE_CYCLES) ? POP_PULSE_CYCLES
                                                               : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  typedef enum logic [1:0] {
    IDLE,
    POP,
    SETTLE,
    ACK
  } state_t;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   win_b_q;      // current transaction belongs to B
  logic                   data_rdy_q;   // previous Data_Rdy, for edge detect
  logic                   pop_q;
  logic                   ack_a_q;
  logic                   ack_b_q;
  logic [DATA_BITS-1:0]   rsp_data_q;
  logic                   rsp_empty_q;
  logic                   wcol_q;

  logic                   any_req;
  logic                   pick_b;
  logic                   wr_rise;

`ifdef RX_FIFO_ARB_FIXED_PRIO_EN
  // A always wins; B only gets the port when A is not asking.
  always_comb begin
    any_req = Req_A | Req_B;
    pick_b  = ~Req_A;
  end
`else
  // Round-robin pointer: 1 means B was granted last, so A wins the next tie.
  logic last_b_q;

  always_comb begin
    any_req = Req_A | Req_B;
    pick_b  = Req_B & (~Req_A | ~last_b_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_b_q <= 1'b1;
    end else if (state_q == ACK) begin
      last_b_q <= win_b_q;
    end
  end
`endif

  always_comb begin
    wr_rise = Data_Rdy & ~data_rdy_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      win_b_q     <= 1'b0;
      data_rdy_q  <= 1'b0;
      pop_q       <= 1'b0;
      ack_a_q     <= 1'b0;
      ack_b_q     <= 1'b0;
      rsp_data_q  <= '0;
      rsp_empty_q <= 1'b0;
      wcol_q      <= 1'b0;
    end else begin
      data_rdy_q <= Data_Rdy;
      // Informational only: flags a write strobe rising under an active pop.
      wcol_q     <= wr_rise & pop_q;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;

      case (state_q)
        IDLE: begin
          if (!BIST_Mode && any_req) begin
            if (FIFO_Empty) begin
              win_b_q     <= pick_b;
              rsp_empty_q <= 1'b1;
              ack_a_q     <= ~pick_b;
              ack_b_q     <= pick_b;
              state_q     <= ACK;
            end else if (!Data_Rdy) begin
              // A concurrent write defers the pop; nothing is committed and
              // arbitration is redone on the next IDLE cycle.
              win_b_q     <= pick_b;
              rsp_empty_q <= 1'b0;
              pop_q       <= 1'b1;
              cnt_q       <= CNT_W'(POP_PULSE_CYCLES - 1);
              state_q     <= POP;
            end
          end
        end

        POP: begin
          if (cnt_q == '0) begin
            pop_q   <= 1'b0;
            cnt_q   <= CNT_W'(SETTLE_CYCLES - 1);
            state_q <= SETTLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        SETTLE: begin
          if (cnt_q == '0) begin
            rsp_data_q <= FIFO_Data;
            ack_a_q    <= ~win_b_q;
            ack_b_q    <= win_b_q;
            state_q    <= ACK;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        ACK: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Pop_Data        = pop_q;
  assign Ack_A           = ack_a_q;
  assign Ack_B           = ack_b_q;
  assign Rsp_Data        = rsp_data_q;
  assign Rsp_Empty       = rsp_empty_q;
  assign Write_Collision = wcol_q;

endmodule

// File: tb/tb_rx_fifo_read_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rx_fifo_read_arbiter
//
// Directed stimulus pushes hand-computed expectations (Ack owner, cycle, data,
// empty flag; Pop_Data pulse start/length; Write_Collision cycle) into queues.
// A negedge monitor pops and compares whenever the DUT presents an event.
// -----------------------------------------------------------------------------
module tb_rx_fifo_read_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       Req_A, Req_B;
  logic       Ack_A, Ack_B;
  logic [7:0] Rsp_Data;
  logic       Rsp_Empty;
  logic [7:0] FIFO_Data;
  logic       FIFO_Empty;
  logic       Data_Rdy;
  logic       BIST_Mode;
  logic       Pop_Data;
  logic       Write_Collision;

  rx_fifo_read_arbiter #(
    .DATA_BITS       (8),
    .POP_PULSE_CYCLES(2),
    .SETTLE_CYCLES   (1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .Req_A          (Req_A),
    .Req_B          (Req_B),
    .Ack_A          (Ack_A),
    .Ack_B          (Ack_B),
    .Rsp_Data       (Rsp_Data),
    .Rsp_Empty      (Rsp_Empty),
    .FIFO_Data      (FIFO_Data),
    .FIFO_Empty     (FIFO_Empty),
    .Data_Rdy       (Data_Rdy),
    .BIST_Mode      (BIST_Mode),
    .Pop_Data       (Pop_Data),
    .Write_Collision(Write_Collision)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         is_b;
    bit         empty;
    logic [7:0] data;
    int         at;
  } ack_t;

  typedef struct {
    int start;
    int len;
  } pop_t;

  ack_t ack_q[$];
  pop_t pop_q[$];
  int   wc_q[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- monitor ----------------
  bit pop_prev  = 1'b0;
  int pop_start = 0;

  always @(negedge clk) begin
    if (Ack_A || Ack_B) begin
      chk("ack_onehot", {31'd0, Ack_A & Ack_B}, 32'd0);
      if (ack_q.size() == 0) begin
        chk("unexpected_ack", 32'd1, 32'd0);
      end else begin
        ack_t e;
        e = ack_q.pop_front();
        chk("ack_owner_b", {31'd0, Ack_B}, {31'd0, e.is_b});
        chk("ack_cycle", cyc, e.at);
        chk("rsp_empty", {31'd0, Rsp_Empty}, {31'd0, e.empty});
        chk("rsp_data", {24'd0, Rsp_Data}, {24'd0, e.data});
      end
    end

    if (Pop_Data && !pop_prev) pop_start = cyc;
    if (!Pop_Data && pop_prev) begin
      if (pop_q.size() == 0) begin
        chk("unexpected_pop", 32'd1, 32'd0);
      end else begin
        pop_t p;
        p = pop_q.pop_front();
        chk("pop_start", pop_start, p.start);
        chk("pop_len", cyc - pop_start, p.len);
      end
    end
    pop_prev = Pop_Data;

    if (Write_Collision) begin
      if (wc_q.size() == 0) begin
        chk("unexpected_collision", 32'd1, 32'd0);
      end else begin
        chk("collision_cycle", cyc, wc_q.pop_front());
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (Ack_A || Ack_B) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL ack_timeout actual=none required=ack within %0d cycles", limit);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_pop", {31'd0, Pop_Data}, 32'd0);
    chk("rst_ack_a", {31'd0, Ack_A}, 32'd0);
    chk("rst_ack_b", {31'd0, Ack_B}, 32'd0);
    chk("rst_rsp_data", {24'd0, Rsp_Data}, 32'd0);
    chk("rst_rsp_empty", {31'd0, Rsp_Empty}, 32'd0);
    chk("rst_collision", {31'd0, Write_Collision}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    rst        = 1'b1;
    Req_A      = 1'b0;
    Req_B      = 1'b0;
    FIFO_Data  = 8'h00;
    FIFO_Empty = 1'b0;
    Data_Rdy   = 1'b0;
    BIST_Mode  = 1'b0;

    step(3);
    rst = 1'b0;
    step(1);
    @(negedge clk);
    chk_reset_outputs();
    step(1);

    // Single pop for A: Pop high t0+1..t0+2, Ack at t0+4.
    t0 = cyc;
    FIFO_Data = 8'hA5;
    Req_A = 1'b1;
    ack_q.push_back('{is_b: 1'b0, empty: 1'b0, data: 8'hA5, at: t0 + 4});
    pop_q.push_back('{start: t0 + 1, len: 2});
    wait_ack(10);
    Req_A = 1'b0;
    step(2);

    // B with FIFO empty: Ack next cycle, no pop, data unchanged.
    t0 = cyc;
    FIFO_Data  = 8'hFF;
    FIFO_Empty = 1'b1;
    Req_B = 1'b1;
    ack_q.push_back('{is_b: 1'b1, empty: 1'b1, data: 8'hA5, at: t0 + 1});
    wait_ack(10);
    Req_B = 1'b0;
    FIFO_Empty = 1'b0;
    step(2);

    // Both requesting for four back-to-back transactions.
    t0 = cyc;
    FIFO_Data = 8'h3C;
    Req_A = 1'b1;
    Req_B = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bit who;
`ifdef RX_FIFO_ARB_FIXED_PRIO_EN
      who = 1'b0;
`else
      who = (i % 2) == 1;
`endif
      ack_q.push_back('{is_b: who, empty: 1'b0, data: 8'h3C, at: t0 + 4 + 5 * i});
      pop_q.push_back('{start: t0 + 1 + 5 * i, len: 2});
    end
    step(20);
    Req_A = 1'b0;
    Req_B = 1'b0;
    step(2);

    // Write strobe high for 3 cycles defers the pop.
    t0 = cyc;
    FIFO_Data = 8'h5E;
    Req_A = 1'b1;
    Data_Rdy = 1'b1;
    ack_q.push_back('{is_b: 1'b0, empty: 1'b0, data: 8'h5E, at: t0 + 7});
    pop_q.push_back('{start: t0 + 4, len: 2});
    step(3);
    Data_Rdy = 1'b0;
    wait_ack(12);
    Req_A = 1'b0;
    step(2);

    // Write strobe rises during the pop pulse.
    t0 = cyc;
    FIFO_Data = 8'hC3;
    Req_A = 1'b1;
    ack_q.push_back('{is_b: 1'b0, empty: 1'b0, data: 8'hC3, at: t0 + 4});
    pop_q.push_back('{start: t0 + 1, len: 2});
    wc_q.push_back(t0 + 2);
    step(1);
    Data_Rdy = 1'b1;
    step(1);
    Data_Rdy = 1'b0;
    wait_ack(10);
    Req_A = 1'b0;
    step(2);

    // Reset in the middle of a pop pulse.
    t0 = cyc;
    FIFO_Data = 8'h77;
    Req_A = 1'b1;
    pop_q.push_back('{start: t0 + 1, len: 1});
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    Req_A = 1'b0;
    @(negedge clk);
    chk_reset_outputs();
    step(3);

    // After reset A wins a tie.
    t0 = cyc;
    FIFO_Data = 8'h5A;
    Req_A = 1'b1;
    Req_B = 1'b1;
    ack_q.push_back('{is_b: 1'b0, empty: 1'b0, data: 8'h5A, at: t0 + 4});
    pop_q.push_back('{start: t0 + 1, len: 2});
    wait_ack(10);
    Req_A = 1'b0;
    Req_B = 1'b0;
    step(3);

    chk("ack_queue_drained", ack_q.size(), 32'd0);
    chk("pop_queue_drained", pop_q.size(), 32'd0);
    chk("collision_queue_drained", wc_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
